// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the unified-SRAM arbiter.
// FSM state encodings (3-bit) and requester grant IDs.
// Helper converts a grant ID into the one-hot grant vector.
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_WAIT_IF = 3'd1,
    ARB_WAIT_LS = 3'd2,
    ARB_RESP_IF = 3'd3,
    ARB_RESP_LS = 3'd4
  } arb_state_t;

  // Requester IDs; bit position in the req/gnt vectors matches the ID
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return (id == GNT_LS) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: req[0]=IF, req[1]=LS.
// Purely combinational, zero latency.
// A tie goes to the requester that was not granted last.
module rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // Pick the winner ID; on a tie alternate away from the last grant
  always_comb begin
    gnt_id = GNT_IF;
    case (req)
      2'b01:   gnt_id = GNT_IF;
      2'b10:   gnt_id = GNT_LS;
      2'b11:   gnt_id = (last == GNT_IF) ? GNT_LS : GNT_IF;
      default: gnt_id = GNT_IF;
    endcase
  end

  // One-hot grant only when somebody is actually requesting
  always_comb begin
    gnt = 2'b00;
    if (|req) gnt = id_to_onehot(gnt_id);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the single SRAM port between IF (read-only) and LS (read/write).
// Latency: grant at N drives the SRAM at N, response valid at N+2; 3 cycles minimum per txn.
// Backpressure: one txn in flight; no new grant until the response handshake completes.
// Optional perf counters enabled by defining SRAM_ARB_PERF_EN.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_resp_valid,
  input  logic          if_resp_ready,
  output logic [DW-1:0] if_resp_rdata,
  input  logic          ls_req_valid,
  output logic          ls_req_ready,
  input  logic [AW-1:0] ls_req_addr,
  input  logic [MW-1:0] ls_req_we,
  input  logic [DW-1:0] ls_req_wdata,
  output logic          ls_resp_valid,
  input  logic          ls_resp_ready,
  output logic [DW-1:0] ls_resp_rdata,
  output logic          sram_en,
  output logic [MW-1:0] sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [63:0]   perf_if_grants,
  output logic [63:0]   perf_ls_grants,
  output logic [63:0]   perf_conflicts
`endif
);

  arb_state_t    state;
  logic          last_grant;
  logic          txn_write;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] ls_rdata_q;

  logic [1:0]    gnt;
  logic          gnt_id;
  logic          grant_en;

  rr_arb2 u_rr_arb2 (
    .req    ({ls_req_valid, if_req_valid}),
    .last   (last_grant),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Grant and SRAM strobe are combinational in IDLE so the access starts the same cycle
  always_comb begin
    grant_en     = (state == ARB_IDLE) && !rst && (if_req_valid || ls_req_valid);
    if_req_ready = grant_en && gnt[0];
    ls_req_ready = grant_en && gnt[1];
    sram_en      = grant_en;
    sram_we      = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    if (grant_en) begin
      if (gnt_id == GNT_LS) begin
        sram_we    = ls_req_we;
        sram_addr  = ls_req_addr;
        sram_wdata = ls_req_wdata;
      end else begin
        sram_addr  = if_req_addr;
      end
    end
  end

  // Response valids decode straight from the registered state
  always_comb begin
    if_resp_valid = (state == ARB_RESP_IF);
    ls_resp_valid = (state == ARB_RESP_LS);
    if_resp_rdata = if_rdata_q;
    ls_resp_rdata = ls_rdata_q;
  end

  // Transaction sequencer: IDLE -> WAIT_x (capture read data) -> RESP_x (hold until taken)
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= GNT_IF;
      txn_write  <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_en) begin
            state      <= (gnt_id == GNT_LS) ? ARB_WAIT_LS : ARB_WAIT_IF;
            last_grant <= gnt_id;
            txn_write  <= (gnt_id == GNT_LS) && (|ls_req_we);
          end
        end
        ARB_WAIT_IF: begin
          if_rdata_q <= sram_rdata;
          state      <= ARB_RESP_IF;
        end
        ARB_WAIT_LS: begin
          // Writes acknowledge with zero data rather than whatever the SRAM drove
          ls_rdata_q <= txn_write ? '0 : sram_rdata;
          state      <= ARB_RESP_LS;
        end
        ARB_RESP_IF: if (if_resp_ready) state <= ARB_IDLE;
        ARB_RESP_LS: if (ls_resp_ready) state <= ARB_IDLE;
        default:     state <= ARB_IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_PERF_EN
  // Grant and conflict counters, free-running and wrapping at 2^64
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_grants <= '0;
      perf_ls_grants <= '0;
      perf_conflicts <= '0;
    end else begin
      if (if_req_ready) perf_if_grants <= perf_if_grants + 64'd1;
      if (ls_req_ready) perf_ls_grants <= perf_ls_grants + 64'd1;
      if ((state == ARB_IDLE) && if_req_valid && ls_req_valid)
        perf_conflicts <= perf_conflicts + 64'd1;
    end
  end
`endif

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single unified SRAM port between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write).
- Sits between the core front-end/LSU and the SRAM wrapper.
- SRAM returns read data registered one cycle after en; the arbiter sequences one transaction at a time.
- Each request gets a buffered response with valid/ready backpressure.

Parameters:
- AW, 64, address width
- DW, 64, data width (SRAM word)
- MW, 8, byte write-mask width (DW/8)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  AW  IF byte address
- if_resp_valid  out  1  IF read data available
- if_resp_ready  in  1  IF consumes response
- if_resp_rdata  out  DW  IF read data
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_req_addr  in  AW  LS byte address
- ls_req_we  in  MW  byte write enables; all-zero = read
- ls_req_wdata  in  DW  LS write data
- ls_resp_valid  out  1  LS response (read data or write ack)
- ls_resp_ready  in  1  LS consumes response
- ls_resp_rdata  out  DW  LS read data; 0 for writes
- sram_en  out  1  SRAM access strobe
- sram_we  out  MW  SRAM byte write enables
- sram_addr  out  AW  SRAM byte address
- sram_wdata  out  DW  SRAM write data
- sram_rdata  in  DW  SRAM registered read data, valid the cycle after sram_en

Behaviour:
- Reset values:
  - state = IDLE.
  - All *_ready, *_resp_valid and sram_en = 0.
  - sram_we = 0; sram_addr, sram_wdata and the response data registers = 0.
  - last_grant = IF.
- FSM states: IDLE, WAIT_IF, WAIT_LS, RESP_IF, RESP_LS.
- IDLE:
  - If any req_valid, pick a winner, assert its req_ready combinationally, and drive sram_en=1 with the winner's addr, wdata and we in the same cycle.
  - IF access always drives we=0.
  - Next state is WAIT_IF or WAIT_LS; last_grant <= winner.
  - If no request: sram_en=0, sram_we=0, stay IDLE.
- WAIT_x:
  - sram_en=0, sram_we=0.
  - Capture sram_rdata into the x response register; write transactions capture 0.
  - Next state RESP_x.
- RESP_x:
  - x_resp_valid=1 with stable data.
  - On x_resp_ready=1, go to IDLE; no new grant in the same cycle.
  - Both req_ready are 0 in every non-IDLE state.
- Latency:
  - Request accepted at cycle N → resp_valid at N+2.
  - Minimum 3 cycles per transaction (IDLE/WAIT/RESP).
- Arbitration:
  - Only one valid → that requester wins.
  - Both valid → the requester not equal to last_grant wins (round-robin).
  - After reset, LS wins the first tie.
- Requesters hold valid and payload stable until ready; the arbiter does not sample payload in other cycles.
- Address is forwarded unmodified. The SRAM ignores addr[2:0]; byte-lane alignment belongs to the requester.
- A withdrawn request (valid dropped before grant) is legal; no access is issued.
- rst asserted mid-transaction:
  - Next state IDLE; the outstanding response is dropped and resp_valid=0.
  - A write already strobed to the SRAM is not undone.
- if_resp_valid and ls_resp_valid are never 1 simultaneously.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_if_grants[63:0], perf_ls_grants[63:0] and perf_conflicts[63:0].
  - The grant counters increment on each granted IF/LS request.
  - perf_conflicts increments in IDLE when both req_valid=1.
  - All counters reset to 0 and wrap modulo 2^64.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- defines.v gets:
  - FSM state encodings (`ARB_IDLE`, `ARB_WAIT_IF`, `ARB_WAIT_LS`, `ARB_RESP_IF`, `ARB_RESP_LS`, 3-bit).
  - Grant IDs `GNT_IF`=0, `GNT_LS`=1.
- One sub-module, rr_arb2:
  - Purely combinational two-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0] one-hot, gnt_id.
- FSM and datapath muxes stay in sram_arbiter.

Test Plan:
1. IF only:
   - Stimulus: if_req addr=0x8000_0000 at cycle N, SRAM model returns 0x1122334455667788.
   - Required: sram_en=1, we=0 at N; if_resp_valid=1 with that data at N+2.
   - With if_resp_ready held 0 for 3 cycles, data and valid stay stable.
2. LS write then read:
   - Stimulus: write we=0x0F, wdata=0xDEADBEEF_CAFEF00D to addr 0x8000_0010; then read the same address.
   - Required: ack has ls_resp_rdata=0; the read returns 0x00000000_CAFEF00D, given upper bytes were previously 0.
3. Conflict:
   - Stimulus: both valid continuously from reset.
   - Required: grants alternate LS, IF, LS, IF; each grant is separated by ≥3 cycles.
   - With SRAM_ARB_PERF_EN: perf_conflicts counts each IDLE cycle with both valid, and perf_if_grants = perf_ls_grants = 2 after 4 grants.
4. Backpressure:
   - Stimulus: LS response held 5 cycles while IF is valid.
   - Required: if_req_ready stays 0 throughout; IF is granted in the first IDLE cycle after the LS handshake.
5. Reset mid-op:
   - Stimulus: assert rst in WAIT_LS.
   - Required: next cycle state=IDLE, ls_resp_valid=0, sram_en=0; the first post-reset tie goes to LS.
6. Withdrawn request:
   - Stimulus: if_req_valid pulses 1 while the arbiter is in RESP_LS, then drops before IDLE.
   - Required: no IF access is issued; sram_en stays 0 in IDLE.
